image_receiver: RTL and testbench
=================================

Name: image_receiver

Overview:
- Receiving end of the pixel-over-UART link.
- Deserialises the serial line with an internal UART receiver and reassembles 2-byte pixels into 15-bit words.
- Writes each pixel into the frame buffer (3072 words) at incrementing addresses.
- Detects the 0xFF end-of-frame marker and reports whether the frame was complete.

Parameters:
CLKS_PER_BIT, 543, clocks per UART bit (passed to uart_rx)
N, 10, width of the uart_rx bit-timing counter
PIXELS, 3072, pixels per complete frame
TIMEOUT_CLKS, 86880, max idle clocks between the high and low byte of one pixel (16 byte-times)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
receive_image  in  1  level; start capturing a frame, sampled only in IDLE
Rx_data  in  1  UART serial input, idle high
pixel_data  out  15  pixel word to the frame buffer
addr_out  out  13  frame-buffer write address
wr_en  out  1  one-cycle write strobe
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse: frame ended with exactly PIXELS pixels
error  out  1  one-cycle pulse: frame ended abnormally

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; pixel_data=0, addr_out=0, wr_en=0, busy=0, done=0, error=0; holding byte and timeout counter cleared; uart_rx reset too.
- Byte format from the sender:
  - High byte = {0, pix[14:8]}.
  - Low byte = pix[7:0], where the sender substitutes 0xFE for 0xFF.
  - End marker = a single 0xFF in high-byte position.
- 0xFE is stored as-is; no correction is attempted.
- uart_rx delivers each byte as o_Rx_Byte with a one-cycle o_Rx_DV pulse.
- IDLE:
  - Outputs 0; addr_out cleared.
  - Bytes arriving here are discarded.
  - receive_image=1 -> WAIT_HIGH.
- WAIT_HIGH, on Rx_DV:
  - byte==0xFF -> END_FRAME.
  - byte[7]==0 -> latch byte[6:0], clear timeout counter -> WAIT_LOW.
  - byte[7]==1 and not 0xFF -> set sticky bad-frame flag, drop byte, stay in WAIT_HIGH.
  - No timeout in this state; the line may idle indefinitely between pixels.
- WAIT_LOW:
  - On Rx_DV with byte!=0xFF -> WRITE, low byte latched.
  - On Rx_DV with byte==0xFF -> set bad flag, discard the pending high byte -> END_FRAME.
  - Timeout counter increments each clock; reaching TIMEOUT_CLKS -> set bad flag, discard the partial pixel -> WAIT_HIGH.
- WRITE (one cycle):
  - If count < PIXELS: pixel_data={hi[6:0],lo}, addr_out=count, wr_en=1 for this cycle, count+1.
  - Else: no write, set bad flag (overflow).
  - Then -> WAIT_HIGH.
  - wr_en is asserted 2 clocks after the Rx_DV of the low byte.
- END_FRAME (one cycle):
  - If count==PIXELS and bad flag clear -> done=1; otherwise error=1.
  - Clear count and bad flag -> IDLE.
- Simultaneous events: receive_image deasserting mid-frame is ignored. If receive_image stays high, a new frame starts on the cycle after return to IDLE.
- count is 13 bits and never wraps, because it saturates at PIXELS.
- addr_out holds the last written address between writes.

Decomposition:
- Shared package: state encoding (IDLE, WAIT_HIGH, WAIT_LOW, WRITE, END_FRAME), END_MARKER=8'hFF, default PIXELS, default CLKS_PER_BIT.
- One sub-module: uart_rx, with ports i_Clock, rst (active-low async), i_Rx_Serial, o_Rx_DV, o_Rx_Byte. Parameters CLKS_PER_BIT and N match uart_tx.
- The frame FSM lives in image_receiver.

Test Plan:
- Full frame: receive_image=1, serial stream of 3072 pixels, pixel k = 15'(k*5), then 0xFF -> 3072 wr_en pulses, addr 0..3071, data matches (low 0xFF seen as 0xFE), single done pulse, no error, busy drops.
- Short frame: 10 pixels then 0xFF -> 10 writes, error pulse, no done, next frame starts at addr 0.
- Protocol faults:
  - High byte 0x85 mid-frame -> no write for that byte; frame of 3072 valid pixels + 0xFF still ends with error.
  - 0xFF in low-byte position -> partial pixel dropped, error pulse, return to IDLE.
- Timeout: high byte 0x12, then silence for TIMEOUT_CLKS -> no write; FSM in WAIT_HIGH; frame ends with error at marker.
- Overflow: 3073 pixels then 0xFF -> exactly 3072 writes (last addr 3071), error pulse.
- Reset mid-frame: assert rst low asynchronously after pixel 100 (between clock edges) -> all outputs 0 immediately; after release with receive_image=1 the next frame writes from addr 0 and ends with done.

Source files
------------

// File: rtl/image_receiver_pkg.sv
// Shared definitions for the pixel-over-UART receiver: FSM encodings, the
// end-of-frame marker and the default link/frame sizes.
package image_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HIGH,
        WAIT_LOW,
        WRITE,
        END_FRAME
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] END_MARKER       = 8'hFF;
    localparam int         DEF_PIXELS       = 3072;
    localparam int         DEF_CLKS_PER_BIT = 543;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples mid-bit, emits each byte with a one-cycle o_Rx_DV.
module uart_rx
    import image_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int N            = 10
) (
    input  logic       i_Clock,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam logic [N-1:0] CNT_HALF = N'((CLKS_PER_BIT - 1) / 2);
    localparam logic [N-1:0] CNT_LAST = N'(CLKS_PER_BIT - 1);

    logic [1:0]   sync_q, sync_d;
    logic         rx;
    rx_state_e    state_q;
    logic [N-1:0] cnt_q;
    logic [2:0]   bit_q;
    logic [7:0]   byte_q;
    logic         dv_q;

    // Two-flop synchroniser; the line idles high so it resets to 1s.
    always_comb sync_d = {sync_q[0], i_Rx_Serial};
    assign rx = sync_q[1];

    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= sync_d;
    end

    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx) state_q <= RX_START;
                end
                RX_START: begin
                    // Re-check at mid start bit so a glitch is not taken as a byte.
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q          <= '0;
                        byte_q[bit_q]  <= rx;
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        dv_q    <= 1'b1;
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;

endmodule

// File: rtl/image_receiver.sv
// Frame receiver: pairs UART bytes into 15-bit pixels, writes them to the
// frame buffer and reports done/error when the 0xFF end marker arrives.
module image_receiver
    import image_receiver_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int N            = 10,
    parameter int PIXELS       = DEF_PIXELS,
    parameter int TIMEOUT_CLKS = 86880
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        receive_image,
    input  logic        Rx_data,
    output logic [14:0] pixel_data,
    output logic [12:0] addr_out,
    output logic        wr_en,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [12:0] PIX_N    = 13'(PIXELS);

    logic        rx_dv;
    logic [7:0]  rx_byte;

    state_e      state_q;
    logic [14:0] pixel_q;
    logic [12:0] addr_q;
    logic        wr_en_q, busy_q, done_q, error_q;
    logic [6:0]  hi_q;
    logic [7:0]  lo_q;
    logic [12:0] count_q;
    logic        bad_q;
    logic [TW-1:0] tmo_q;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .N            (N)
    ) u_uart_rx (
        .i_Clock     (clk),
        .rst         (rst),
        .i_Rx_Serial (Rx_data),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pixel_q <= '0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pixel_q <= '0;
                    addr_q  <= '0;
                    count_q <= '0;
                    bad_q   <= 1'b0;
                    if (receive_image) begin
                        state_q <= WAIT_HIGH;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_dv) begin
                        if (rx_byte == END_MARKER) begin
                            state_q <= END_FRAME;
                        end else if (!rx_byte[7]) begin
                            hi_q    <= rx_byte[6:0];
                            tmo_q   <= '0;
                            state_q <= WAIT_LOW;
                        end else begin
                            bad_q <= 1'b1;
                        end
                    end
                end
                WAIT_LOW: begin
                    // A marker here means the sender aborted mid-pixel.
                    if (rx_dv) begin
                        if (rx_byte == END_MARKER) begin
                            bad_q   <= 1'b1;
                            state_q <= END_FRAME;
                        end else begin
                            lo_q    <= rx_byte;
                            state_q <= WRITE;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        bad_q   <= 1'b1;
                        state_q <= WAIT_HIGH;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (count_q < PIX_N) begin
                        pixel_q <= {hi_q, lo_q};
                        addr_q  <= count_q;
                        wr_en_q <= 1'b1;
                        count_q <= count_q + 13'd1;
                    end else begin
                        bad_q <= 1'b1;
                    end
                    state_q <= WAIT_HIGH;
                end
                END_FRAME: begin
                    if (count_q == PIX_N && !bad_q) done_q  <= 1'b1;
                    else                            error_q <= 1'b1;
                    count_q <= '0;
                    bad_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_data = pixel_q;
    assign addr_out   = addr_q;
    assign wr_en      = wr_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_image_receiver.sv
// Directed bench for image_receiver with a shrunk frame and fast UART timing.
module tb_image_receiver;

    localparam int CPB = 8;
    localparam int NW  = 4;
    localparam int PIX = 8;
    localparam int TMO = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        receive_image = 1'b0;
    logic        Rx_data = 1'b1;
    logic [14:0] pixel_data;
    logic [12:0] addr_out;
    logic        wr_en, busy, done, error;

    image_receiver #(
        .CLKS_PER_BIT (CPB),
        .N            (NW),
        .PIXELS       (PIX),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .receive_image (receive_image),
        .Rx_data       (Rx_data),
        .pixel_data    (pixel_data),
        .addr_out      (addr_out),
        .wr_en         (wr_en),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;
    int n_done = 0;
    int n_err = 0;
    int wbase = 0, dbase = 0, ebase = 0;
    logic [14:0] wr_data[$];
    logic [12:0] wr_addr[$];
    logic [14:0] exp_q[$];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_data.push_back(pixel_data);
            wr_addr.push_back(addr_out);
        end
        if (done)  n_done++;
        if (error) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        Rx_data = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            Rx_data = b[i];
            clks(CPB);
        end
        Rx_data = 1'b1;
        clks(3 * CPB);
    endtask

    task automatic send_pixel(input logic [14:0] p);
        logic [7:0] lo;
        lo = (p[7:0] == 8'hFF) ? 8'hFE : p[7:0];
        exp_q.push_back({p[14:8], lo});
        send_byte({1'b0, p[14:8]});
        send_byte(lo);
    endtask

    task automatic start_frame(input bit hold);
        exp_q.delete();
        wbase = wr_data.size();
        dbase = n_done;
        ebase = n_err;
        receive_image = 1'b1;
        clks(2);
        if (!hold) receive_image = 1'b0;
    endtask

    task automatic end_frame(input string tag, input int n_wr, input int exp_done,
                             input int exp_err, input logic exp_busy);
        send_byte(8'hFF);
        clks(10);
        @(negedge clk);
        chk({tag, "_writes"}, wr_data.size() - wbase, n_wr);
        for (int i = 0; i < n_wr && wbase + i < wr_data.size(); i++) begin
            chk({tag, "_addr"}, wr_addr[wbase + i], i);
            chk({tag, "_data"}, wr_data[wbase + i], exp_q[i]);
        end
        chk({tag, "_done"}, n_done - dbase, exp_done);
        chk({tag, "_error"}, n_err - ebase, exp_err);
        chk({tag, "_busy"}, busy, exp_busy);
    endtask

    initial begin
        // Reset state
        clks(4);
        @(negedge clk);
        chk("rst_pixel", pixel_data, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        rst = 1'b1;
        clks(4);

        // Bytes received while idle are dropped
        send_byte(8'h05);
        send_byte(8'h10);
        @(negedge clk);
        chk("idle_writes", wr_data.size(), 0);
        chk("idle_busy", busy, 0);

        // Complete frame; receive_image drops mid-frame and is ignored
        start_frame(1'b0);
        chk("full_busy_start", busy, 1);
        for (int k = 0; k < PIX; k++) begin
            send_pixel((k == 5) ? 15'h12FF : 15'(k * 5));
            if (k == 3) chk("full_addr_hold", addr_out, 3);
        end
        end_frame("full", PIX, 1, 0, 1'b0);
        chk("full_data_fe", wr_data[wbase + 5], 15'h12FE);

        // Short frame
        start_frame(1'b0);
        for (int k = 0; k < 3; k++) send_pixel(15'(k + 15'h0040));
        end_frame("short", 3, 0, 1, 1'b0);

        // Bad high byte mid-frame
        start_frame(1'b0);
        for (int k = 0; k < PIX; k++) begin
            if (k == 2) send_byte(8'h85);
            send_pixel(15'(k + 15'h0200));
        end
        end_frame("badhi", PIX, 0, 1, 1'b0);

        // Marker in low-byte position
        start_frame(1'b0);
        send_pixel(15'h0102);
        send_byte(8'h12);
        end_frame("fflow", 1, 0, 1, 1'b0);

        // Timeout between high and low byte
        start_frame(1'b0);
        send_pixel(15'h0777);
        send_byte(8'h12);
        clks(TMO + 40);
        @(negedge clk);
        chk("tmo_no_write", wr_data.size() - wbase, 1);
        chk("tmo_busy", busy, 1);
        send_pixel(15'h0345);
        end_frame("tmo", 2, 0, 1, 1'b0);

        // Overflow: one pixel too many
        start_frame(1'b0);
        for (int k = 0; k <= PIX; k++) send_pixel(15'(k * 3 + 15'h0100));
        end_frame("ovf", PIX, 0, 1, 1'b0);
        chk("ovf_last_addr", wr_addr[wr_addr.size() - 1], PIX - 1);

        // Asynchronous reset mid-frame, then a full frame with receive_image held
        start_frame(1'b0);
        for (int k = 0; k < 3; k++) send_pixel(15'(k + 1));
        chk("mrst_busy_before", busy, 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_addr", addr_out, 0);
        chk("mrst_pixel", pixel_data, 0);
        chk("mrst_wr_en", wr_en, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start_frame(1'b1);
        for (int k = 0; k < PIX; k++) send_pixel(15'(k * 7 + 15'h0300));
        end_frame("after_rst", PIX, 1, 0, 1'b1);
        receive_image = 1'b0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
